// File: rtl/tproj_tx_memory_pkg.sv
// Shared definitions for the projection link (TX and RX ends).
package tproj_tx_memory_pkg;

  localparam int DATA_W      = 55;
  localparam int TAG_MSB     = 54;
  localparam int TAG_LSB     = 51;
  localparam int DEPTH       = 16;
  localparam int MAX_PER_EVT = 32;
  localparam int CNT_W       = 16;

  // Wide enough to hold the value MAX_PER_EVT itself.
  localparam int EVT_W = $clog2(MAX_PER_EVT + 1);

  // A zero tag means "no word", so the all-zeros word is the link idle word.
  localparam logic [DATA_W-1:0] LINK_IDLE_WORD = {DATA_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_CAPPED = 2'd2
  } tx_state_e;

  // True when the word carries a real projection (nonzero tag).
  function automatic logic tag_nonzero(input logic [DATA_W-1:0] word);
    return |word[TAG_MSB:TAG_LSB];
  endfunction

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (&value) begin
      return value;
    end else begin
      return value + CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/tproj_tx_memory_fifo.sv
// Single-clock FIFO. No bypass: a word written at an edge is readable
// from the head only after that edge. Push while full and pop while
// empty are ignored.
module proj_sync_fifo #(
  parameter int DATA_W = 55,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == CW'(0));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Next pointer and occupancy values; pointers wrap naturally modulo DEPTH.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards all buffered words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/tproj_tx_memory.sv
// Transmit-side projection buffer: accepts projections, applies the
// per-event cap, buffers them and launches one word per cycle on the link.
module tproj_tx_memory
  import tproj_tx_memory_pkg::*;
(
  input  logic              proc_clk,
  input  logic              reset,
  input  logic              start_evt,
  input  logic [DATA_W-1:0] proj_in,
  input  logic              proj_in_valid,
  output logic              proj_in_ready,
  input  logic              link_full,
  output logic [DATA_W-1:0] proj_out,
  output logic [CNT_W-1:0]  n_sent,
  output logic [CNT_W-1:0]  n_dropped,
  output logic              busy
);

  localparam int FCW = $clog2(DEPTH) + 1;

  tx_state_e         state_q, state_d;
  tx_state_e         state_base;
  logic [EVT_W-1:0]  evt_cnt_q, evt_cnt_d;
  logic [EVT_W-1:0]  evt_cnt_base;
  logic [DATA_W-1:0] proj_out_q, proj_out_d;
  logic [CNT_W-1:0]  n_sent_q, n_sent_d;
  logic [CNT_W-1:0]  n_dropped_q, n_dropped_d;

  logic              accept;
  logic              in_event;
  logic              fifo_push;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCW-1:0]    fifo_count;

  proj_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (proc_clk),
    .rst_n     (reset),
    .push      (fifo_push),
    .push_data (proj_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Intake: ready per state, cap/zero-tag filtering, event counting and next state.
  always_comb begin
    proj_in_ready = 1'b0;
    fifo_push     = 1'b0;
    n_dropped_d   = n_dropped_q;
    case (state_q)
      ST_IDLE:   proj_in_ready = 1'b0;
      ST_ACTIVE: proj_in_ready = !fifo_full;
      ST_CAPPED: proj_in_ready = 1'b1;
      default:   proj_in_ready = 1'b0;
    endcase
    accept = proj_in_valid && proj_in_ready;

    // A start pulse opens a new event this very cycle, so a word accepted
    // alongside it is the first word of the new event.
    if (start_evt) begin
      evt_cnt_base = EVT_W'(0);
      state_base   = ST_ACTIVE;
    end else begin
      evt_cnt_base = evt_cnt_q;
      state_base   = state_q;
    end
    in_event  = (state_base == ST_ACTIVE);
    evt_cnt_d = evt_cnt_base;

    if (accept) begin
      // Full FIFO can only coincide with an accept when a start pulse
      // arrives in CAPPED (ready=1); such a word is dropped, not lost silently.
      if (in_event && tag_nonzero(proj_in) && !fifo_full) begin
        fifo_push = 1'b1;
        evt_cnt_d = evt_cnt_base + EVT_W'(1);
      end else begin
        n_dropped_d = sat_inc(n_dropped_q);
      end
    end else begin
      evt_cnt_d = evt_cnt_base;
    end

    if (in_event && (evt_cnt_d >= EVT_W'(MAX_PER_EVT))) begin
      state_d = ST_CAPPED;
    end else begin
      state_d = state_base;
    end
  end

  // Drain: launch the head word whenever the link can take it, else idle word.
  always_comb begin
    fifo_pop   = !link_full && !fifo_empty;
    proj_out_d = LINK_IDLE_WORD;
    n_sent_d   = n_sent_q;
    if (fifo_pop) begin
      proj_out_d = fifo_head;
      n_sent_d   = sat_inc(n_sent_q);
    end else begin
      proj_out_d = LINK_IDLE_WORD;
      n_sent_d   = n_sent_q;
    end
  end

  // Control state, link word and statistics registers.
  always_ff @(posedge proc_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      evt_cnt_q   <= EVT_W'(0);
      proj_out_q  <= LINK_IDLE_WORD;
      n_sent_q    <= CNT_W'(0);
      n_dropped_q <= CNT_W'(0);
    end else begin
      state_q     <= state_d;
      evt_cnt_q   <= evt_cnt_d;
      proj_out_q  <= proj_out_d;
      n_sent_q    <= n_sent_d;
      n_dropped_q <= n_dropped_d;
    end
  end

  assign proj_out  = proj_out_q;
  assign n_sent    = n_sent_q;
  assign n_dropped = n_dropped_q;
  assign busy      = (state_q != ST_IDLE) || (fifo_count != FCW'(0));

endmodule

// File: tb/tb_tproj_tx_memory.sv
// Self-checking bench for tproj_tx_memory: directed table, corner-case
// sequences and a randomized run against a queue-based reference model.
module tb_tproj_tx_memory;

  localparam int DW = 55;

  logic          proc_clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_evt = 1'b0;
  logic [DW-1:0] proj_in = '0;
  logic          proj_in_valid = 1'b0;
  logic          proj_in_ready;
  logic          link_full = 1'b0;
  logic [DW-1:0] proj_out;
  logic [15:0]   n_sent;
  logic [15:0]   n_dropped;
  logic          busy;

  tproj_tx_memory dut (
    .proc_clk      (proc_clk),
    .reset         (reset),
    .start_evt     (start_evt),
    .proj_in       (proj_in),
    .proj_in_valid (proj_in_valid),
    .proj_in_ready (proj_in_ready),
    .link_full     (link_full),
    .proj_out      (proj_out),
    .n_sent        (n_sent),
    .n_dropped     (n_dropped),
    .busy          (busy)
  );

  always #5 proc_clk = ~proc_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: event mode, words forwarded this event, a queue for the buffer.
  int            m_mode;   // 0 = no event open, 1 = forwarding, 2 = capped
  int            m_ecnt;
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_out;
  int            m_sent;
  int            m_drop;

  bit last_acc;
  bit ready_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [3:0] tag, input int payload);
    logic [50:0] p;
    p = 51'(payload);
    return {tag, p};
  endfunction

  function automatic bit m_ready();
    if (m_mode == 0) return 1'b0;
    else if (m_mode == 1) return (m_q.size() < 16);
    else return 1'b1;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_ecnt = 0;
    m_q.delete();
    m_out  = '0;
    m_sent = 0;
    m_drop = 0;
  endtask

  task automatic model_edge(input bit st, input bit v, input logic [DW-1:0] d, input bit lf);
    bit acc;
    bit open_evt;
    int sz;
    acc = v && m_ready();
    sz  = m_q.size();
    open_evt = st || (m_mode == 1);
    if (!lf && sz > 0) begin
      m_out = m_q.pop_front();
      if (m_sent < 65535) m_sent++;
    end else begin
      m_out = '0;
    end
    if (st) m_ecnt = 0;
    if (acc) begin
      if (open_evt && d[54:51] != 4'h0 && sz < 16) begin
        m_q.push_back(d);
        m_ecnt++;
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end
    if (st) m_mode = 1;
    if (m_mode == 1 && m_ecnt >= 32) m_mode = 2;
  endtask

  // One clock cycle: drive, check ready, clock, check registered outputs.
  task automatic step(input bit st, input bit v, input logic [DW-1:0] d, input bit lf);
    start_evt = st;
    proj_in_valid = v;
    proj_in = d;
    link_full = lf;
    #1;
    ready_seen = proj_in_ready;
    check("ready", proj_in_ready, m_ready());
    last_acc = v && m_ready();
    @(posedge proc_clk);
    model_edge(st, v, d, lf);
    #1;
    check("proj_out", proj_out, m_out);
    check("n_sent", n_sent, m_sent);
    check("n_dropped", n_dropped, m_drop);
    check("busy", busy, (m_mode != 0) || (m_q.size() > 0));
  endtask

  // Asynchronous reset away from the clock edge; outputs must clear at once.
  task automatic do_reset();
    start_evt = 1'b0;
    proj_in_valid = 1'b0;
    link_full = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_proj_out", proj_out, 64'd0);
    check("rst_ready", proj_in_ready, 64'd0);
    check("rst_n_sent", n_sent, 64'd0);
    check("rst_busy", busy, 64'd0);
    model_reset();
    #2;
    reset = 1'b1;
  endtask

  typedef struct {
    bit            st;
    bit            v;
    logic [DW-1:0] d;
    bit            exp_rdy;
    logic [DW-1:0] exp_out;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [DW-1:0] got[$];
    int idx;
    int first_c;
    int last_c;
    int bad_rdy;
    int nz;

    model_reset();
    #12;
    check("por_proj_out", proj_out, 64'd0);
    check("por_ready", proj_in_ready, 64'd0);
    check("por_busy", busy, 64'd0);
    @(negedge proc_clk);
    reset = 1'b1;

    // Idle gating (no event yet), then three words through with 1-cycle latency.
    tbl[0] = '{1'b0, 1'b1, mk(4'h5, 'h55), 1'b0, '0};
    tbl[1] = '{1'b0, 1'b1, mk(4'h5, 'h55), 1'b0, '0};
    tbl[2] = '{1'b1, 1'b0, '0,             1'b0, '0};
    tbl[3] = '{1'b0, 1'b1, mk(4'h1, 'hA1), 1'b1, '0};
    tbl[4] = '{1'b0, 1'b1, mk(4'h2, 'hA2), 1'b1, mk(4'h1, 'hA1)};
    tbl[5] = '{1'b0, 1'b1, mk(4'h3, 'hA3), 1'b1, mk(4'h2, 'hA2)};
    tbl[6] = '{1'b0, 1'b0, '0,             1'b1, mk(4'h3, 'hA3)};
    tbl[7] = '{1'b0, 1'b0, '0,             1'b1, '0};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].st, tbl[i].v, tbl[i].d, 1'b0);
      check($sformatf("t1_ready_%0d", i), ready_seen, tbl[i].exp_rdy);
      check($sformatf("t1_out_%0d", i), proj_out, tbl[i].exp_out);
    end
    check("t1_n_sent", n_sent, 64'd3);

    // Truncation cap: 40 words, 32 forwarded, 8 dropped, never stalled.
    do_reset();
    step(1'b1, 1'b0, '0, 1'b0);
    bad_rdy = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, mk(4'((i % 15) + 1), i), 1'b0);
      if (i >= 32 && !ready_seen) bad_rdy++;
    end
    check("t3_capped_ready_low", bad_rdy, 64'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0);
    check("t3_n_sent", n_sent, 64'd32);
    check("t3_n_dropped", n_dropped, 64'd8);
    step(1'b1, 1'b1, mk(4'h7, 'h777), 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    check("t3_new_evt_word", proj_out, mk(4'h7, 'h777));
    check("t3_n_sent_33", n_sent, 64'd33);

    // Back-pressure: fill 16, hold, then release and drain 20 in order.
    do_reset();
    step(1'b1, 1'b0, '0, 1'b1);
    idx = 0;
    for (int c = 0; c < 22; c++) begin
      step(1'b0, 1'b1, mk(4'h9, idx), 1'b1);
      if (last_acc) idx++;
    end
    check("t4_accepted_while_full", idx, 64'd16);
    check("t4_ready_dropped", ready_seen, 64'd0);
    first_c = -1;
    last_c = -1;
    for (int c = 0; c < 40; c++) begin
      if (idx < 20) step(1'b0, 1'b1, mk(4'h9, idx), 1'b0);
      else step(1'b0, 1'b0, '0, 1'b0);
      if (last_acc) idx++;
      if (proj_out != '0) begin
        got.push_back(proj_out);
        if (first_c < 0) first_c = c;
        last_c = c;
      end
    end
    check("t4_count", got.size(), 64'd20);
    check("t4_no_gaps", last_c - first_c + 1, 64'd20);
    for (int i = 0; i < got.size(); i++) check($sformatf("t4_order_%0d", i), got[i], mk(4'h9, i));

    // Zero-tag filtering, then start coincident with an accept counts as word 1.
    do_reset();
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, (i % 2 == 0) ? mk(4'h0, 'h300 + i) : mk(4'hC, 'h300 + i), 1'b0);
    end
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, '0, 1'b0);
    check("t5_dropped_zero", n_dropped, 64'd6);
    check("t5_sent", n_sent, 64'd6);
    step(1'b1, 1'b1, mk(4'h3, 'h400), 1'b0);
    for (int i = 1; i < 32; i++) step(1'b0, 1'b1, mk(4'h3, 'h400 + i), 1'b0);
    check("t5_dropped_before_cap", n_dropped, 64'd6);
    step(1'b0, 1'b1, mk(4'h3, 'h4FF), 1'b0);
    check("t5_dropped_at_cap", n_dropped, 64'd7);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, '0, 1'b0);
    check("t5_sent_total", n_sent, 64'd38);

    // Reset with five words still buffered: nothing stale afterwards.
    do_reset();
    step(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, mk(4'hE, 'h500 + i), 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);
    check("t6_word_on_link", proj_out, mk(4'hE, 'h500));
    do_reset();
    #1;
    check("t6_busy", busy, 64'd0);
    check("t6_n_sent", n_sent, 64'd0);
    nz = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, '0, 1'b0);
      if (proj_out != '0) nz++;
    end
    check("t6_no_stale", nz, 64'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit st;
      bit v;
      bit lf;
      logic [3:0] tg;
      st = ($urandom_range(0, 59) == 0);
      v  = ($urandom_range(0, 9) < 7);
      lf = ($urandom_range(0, 9) < 3);
      tg = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      step(st, v, mk(tg, int'($urandom)), lf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
